// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace capture path.
package trace_pkg;

    localparam int unsigned STAMP_W   = 14;
    localparam int unsigned REG_NUM_W = 5;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned WORD_W    = 32;

    // Header word bit positions
    localparam int unsigned HDR_REG_EV_BIT  = 31;
    localparam int unsigned HDR_WR_BIT      = 30;
    localparam int unsigned HDR_RD_BIT      = 29;
    localparam int unsigned HDR_REG_NUM_LSB = 24;
    localparam int unsigned HDR_LOST_BIT    = 23;
    localparam int unsigned HDR_STAMP_LSB   = 9;
    localparam int unsigned HDR_ADDR_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        REG,
        MEM
    } ser_state_t;

    typedef struct packed {
        logic                 reg_ev;
        logic                 wr;
        logic                 rd;
        logic [REG_NUM_W-1:0] reg_num;
        logic                 lost;
        logic [STAMP_W-1:0]   stamp;
        logic [ADDR_W-1:0]    addr;
        logic [WORD_W-1:0]    reg_data;
        logic [WORD_W-1:0]    mem_data;
    } trace_rec_t;

    // Pack the first word of a record
    function automatic logic [WORD_W-1:0] make_header(input trace_rec_t r);
        logic [WORD_W-1:0] h;
        h = '0;
        h[HDR_REG_EV_BIT]                    = r.reg_ev;
        h[HDR_WR_BIT]                        = r.wr;
        h[HDR_RD_BIT]                        = r.rd;
        h[HDR_REG_NUM_LSB +: REG_NUM_W]      = r.reg_num;
        h[HDR_LOST_BIT]                      = r.lost;
        h[HDR_STAMP_LSB +: STAMP_W]          = r.stamp;
        h[HDR_ADDR_LSB +: ADDR_W]            = r.addr;
        return h;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Push is refused when full; pop is ignored when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Turns per-cycle core register/memory activity into timestamped records,
// buffers them, and streams them out as 32-bit words. Never stalls the core:
// records arriving while the buffer is full are dropped and counted.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic                   reg_write_sig,
    input  logic [4:0]             reg_num,
    input  logic [31:0]            reg_data,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [8:0]             addr,
    input  logic [31:0]            wr_data,
    input  logic [31:0]            rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] level,
    output logic [DROP_W-1:0]      drop_count
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic               reg_ev;
    logic               mem_ev;
    logic               rec_ev;
    logic               push;
    logic               drop;
    logic               pop;
    logic               lost_pending;
    logic [STAMP_W-1:0] stamp;
    trace_rec_t         new_rec;
    trace_rec_t         head_rec;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LW-1:0]      fifo_level;
    logic               head_mem_ev;
    logic               more_after_pop;
    ser_state_t         state;
    ser_state_t         state_nxt;

    assign reg_ev = trace_en && reg_write_sig && (reg_num != '0);
    assign mem_ev = trace_en && (wr || rd);
    assign rec_ev = reg_ev || mem_ev;
    assign push   = rec_ev && !fifo_full;
    assign drop   = rec_ev && fifo_full;

    // Assemble the record for this cycle's activity
    always_comb begin
        new_rec          = '0;
        new_rec.reg_ev   = reg_ev;
        new_rec.wr       = trace_en && wr;
        new_rec.rd       = trace_en && rd;
        new_rec.reg_num  = reg_ev ? reg_num : '0;
        new_rec.lost     = lost_pending;
        new_rec.stamp    = stamp;
        new_rec.addr     = mem_ev ? addr : '0;
        new_rec.reg_data = reg_ev ? reg_data : '0;
        new_rec.mem_data = mem_ev ? (wr ? wr_data : rd_data) : '0;
    end

    // Free-running timestamp, zero in the first cycle out of reset
    always_ff @(posedge clk) begin
        if (reset) stamp <= '0;
        else       stamp <= stamp + 1'b1;
    end

    // Drop accounting and the sticky flag that marks the next kept record
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count   <= '0;
            lost_pending <= 1'b0;
        end else if (push) begin
            lost_pending <= 1'b0;
        end else if (drop) begin
            lost_pending <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (new_rec),
        .pop   (pop),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign level       = fifo_level;
    assign head_mem_ev = head_rec.wr || head_rec.rd;

    // A push this cycle counts as "another record present" so that a record
    // arriving into an empty buffer, or behind the one being popped, is
    // presented the very next cycle without a bubble.
    assign more_after_pop = (fifo_level > LW'(1)) || push;

    // Serializer state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Serializer word selection and sequencing
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty || push) state_nxt = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = make_header(head_rec);
                if (out_ready) state_nxt = head_rec.reg_ev ? REG : MEM;
            end
            REG: begin
                out_valid = 1'b1;
                out_data  = head_rec.reg_data;
                out_last  = !head_mem_ev;
                if (out_ready) begin
                    if (head_mem_ev) begin
                        state_nxt = MEM;
                    end else begin
                        pop       = 1'b1;
                        state_nxt = more_after_pop ? HDR : IDLE;
                    end
                end
            end
            MEM: begin
                out_valid = 1'b1;
                out_data  = head_rec.mem_data;
                out_last  = 1'b1;
                if (out_ready) begin
                    pop       = 1'b1;
                    state_nxt = more_after_pop ? HDR : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
